agex_stage: RTL and testbench

//  Address-generate/execute stage; sits directly downstream of the decode stage.

---
 rtl/agex_stage_if.sv | 51 +++++
 rtl/agex_stage.sv | 137 +++++++++++++
 tb/tb_agex_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/agex_stage_if.sv
// Decode-to-AGEX bundle: decoded operands in, forwarding/redirect/MEM-stage outputs back.
// MEM_OVF exists only when AGEX_OVF_FLAG_EN is defined.
interface agex_stage_if #(
   parameter int WIDTH = 16
);
   logic             VALID_IN;
   logic [1:0]       ALUOP;
   logic [WIDTH-1:0] OPERAND1;
   logic [WIDTH-1:0] OPERAND2;
   logic [2:0]       DR_IN;
   logic [WIDTH-1:0] PC_IN;
   logic [WIDTH-1:0] PC_OFFSET;
   logic [WIDTH-1:0] MEM_OFFSET;
   logic             BRANCH_IN;
   logic             MEM_STALL;
   logic [WIDTH-1:0] AGEX_RESULT;
   logic [1:0]       OP_EX;
   logic [2:0]       DR_EX;
   logic             STALL_OUT;
   logic             BR_TAKEN;
   logic [WIDTH-1:0] BR_TARGET;
   logic             MEM_VALID;
   logic [1:0]       OP_MEM;
   logic [2:0]       DR_MEM;
   logic [WIDTH-1:0] MEM_ADDR;
   logic [WIDTH-1:0] MEM_WDATA;
   logic [2:0]       CC;
`ifdef AGEX_OVF_FLAG_EN
   logic             MEM_OVF;
`endif

   modport master (
      output VALID_IN, ALUOP, OPERAND1, OPERAND2, DR_IN, PC_IN, PC_OFFSET,
             MEM_OFFSET, BRANCH_IN, MEM_STALL,
      input  AGEX_RESULT, OP_EX, DR_EX, STALL_OUT, BR_TAKEN, BR_TARGET,
             MEM_VALID, OP_MEM, DR_MEM, MEM_ADDR, MEM_WDATA, CC
`ifdef AGEX_OVF_FLAG_EN
      , input MEM_OVF
`endif
   );

   modport slave (
      input  VALID_IN, ALUOP, OPERAND1, OPERAND2, DR_IN, PC_IN, PC_OFFSET,
             MEM_OFFSET, BRANCH_IN, MEM_STALL,
      output AGEX_RESULT, OP_EX, DR_EX, STALL_OUT, BR_TAKEN, BR_TARGET,
             MEM_VALID, OP_MEM, DR_MEM, MEM_ADDR, MEM_WDATA, CC
`ifdef AGEX_OVF_FLAG_EN
      , output MEM_OVF
`endif
   );
endinterface

// File: rtl/agex_stage.sv
// Address-generate/execute stage: ADD, LDW/STW address, branch redirect + flush, CC register.
// Optional AGEX_OVF_FLAG_EN adds the registered signed-overflow flag MEM_OVF.
module agex_stage #(
   parameter int         WIDTH        = 16,
   parameter int         FLUSH_CYCLES = 2,
   parameter logic [2:0] CC_RESET     = 3'b010
) (
   input logic         CLK,
   input logic         RESET,
   agex_stage_if.slave bus
);
   localparam logic [1:0] OP_BR  = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   function automatic logic [2:0] cc_of(input logic signed [WIDTH-1:0] v);
      if (v == 0)     return 3'b010;
      else if (v < 0) return 3'b100;
      else            return 3'b001;
   endfunction

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   logic signed [WIDTH-1:0] op1_s, op2_s, moff_s, sum_s, addr_s;
   logic [WIDTH-1:0]        target_p0;
   logic                    eff_v_p0, is_add_p0, take_p0;
   logic [1:0]              op_ex_p0;

   // ---- stage p0: combinational execute ----
   assign op1_s     = bus.OPERAND1;
   assign op2_s     = bus.OPERAND2;
   assign moff_s    = bus.MEM_OFFSET;
   assign sum_s     = op1_s + op2_s;
   assign addr_s    = op1_s + (moff_s <<< 1);
   assign target_p0 = bus.PC_IN + (bus.PC_OFFSET << 1);

   assign eff_v_p0  = bus.VALID_IN && (state_q == IDLE);
   assign is_add_p0 = (bus.ALUOP == OP_ADD);
   assign take_p0   = eff_v_p0 && (bus.ALUOP == OP_BR) && bus.BRANCH_IN;
   assign op_ex_p0  = eff_v_p0 ? bus.ALUOP : OP_BR;

   assign bus.AGEX_RESULT = is_add_p0 ? sum_s : addr_s;
   assign bus.OP_EX       = op_ex_p0;
   assign bus.DR_EX       = bus.DR_IN;
   assign bus.STALL_OUT   = bus.MEM_STALL;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!bus.MEM_STALL) begin
         case (state_q)
            IDLE: begin
               if (take_p0) begin
                  state_d = FLUSH;
                  cnt_d   = CNT_INIT;
               end
            end
            FLUSH: begin
               if (cnt_q == 3'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---- stage p1: MEM-side registers ----
   logic             vld_p1, br_taken_p1;
   logic [1:0]       op_p1;
   logic [2:0]       dr_p1, cc_p1;
   logic [WIDTH-1:0] addr_p1, wdata_p1, br_target_p1;
`ifdef AGEX_OVF_FLAG_EN
   logic             ovf_p1;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_p1       <= 1'b0;
         op_p1        <= 2'b00;
         dr_p1        <= 3'd0;
         addr_p1      <= '0;
         wdata_p1     <= '0;
         br_taken_p1  <= 1'b0;
         br_target_p1 <= '0;
         cc_p1        <= CC_RESET;
`ifdef AGEX_OVF_FLAG_EN
         ovf_p1       <= 1'b0;
`endif
      end else if (!bus.MEM_STALL) begin
         // A BR never enters MEM as a live instruction; its only effect is the redirect.
         vld_p1      <= eff_v_p0 && (bus.ALUOP != OP_BR);
         op_p1       <= op_ex_p0;
         dr_p1       <= bus.DR_IN;
         addr_p1     <= bus.AGEX_RESULT;
         wdata_p1    <= bus.OPERAND2;
         br_taken_p1 <= take_p0;
         if (take_p0)
            br_target_p1 <= target_p0;
         if (eff_v_p0 && is_add_p0)
            cc_p1 <= cc_of(sum_s);
`ifdef AGEX_OVF_FLAG_EN
         ovf_p1      <= eff_v_p0 && is_add_p0 && add_ovf(op1_s, op2_s, sum_s);
`endif
      end
   end

   assign bus.MEM_VALID = vld_p1;
   assign bus.OP_MEM    = op_p1;
   assign bus.DR_MEM    = dr_p1;
   assign bus.MEM_ADDR  = addr_p1;
   assign bus.MEM_WDATA = wdata_p1;
   assign bus.BR_TAKEN  = br_taken_p1;
   assign bus.BR_TARGET = br_target_p1;
   assign bus.CC        = cc_p1;
`ifdef AGEX_OVF_FLAG_EN
   assign bus.MEM_OVF   = ovf_p1;
`endif
endmodule

// File: tb/tb_agex_stage.sv
// Directed self-checking bench for agex_stage (default WIDTH=16, FLUSH_CYCLES=2).
module tb_agex_stage;
   logic CLK;
   logic RESET;
   int   n_pass;
   int   n_total;

   agex_stage_if #(.WIDTH(16)) bus ();

   agex_stage #(.WIDTH(16), .FLUSH_CYCLES(2), .CC_RESET(3'b010)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] dr, input logic [15:0] moff);
      bus.VALID_IN   = v;
      bus.ALUOP      = op;
      bus.OPERAND1   = a;
      bus.OPERAND2   = b;
      bus.DR_IN      = dr;
      bus.MEM_OFFSET = moff;
      bus.BRANCH_IN  = 1'b0;
      #1;
   endtask

   task automatic drive_br(input logic taken, input logic [15:0] pc, input logic [15:0] off);
      drive(1'b1, 2'b00, 16'h0, 16'h0, 3'd0, 16'h0);
      bus.PC_IN     = pc;
      bus.PC_OFFSET = off;
      bus.BRANCH_IN = taken;
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      n_total++; if (bus.MEM_VALID !== 1'b0) $display("FAIL rst_mem_valid got %b want 0", bus.MEM_VALID); else n_pass++;
      n_total++; if (bus.OP_MEM !== 2'b00) $display("FAIL rst_op_mem got %b want 00", bus.OP_MEM); else n_pass++;
      n_total++; if (bus.MEM_ADDR !== 16'h0) $display("FAIL rst_mem_addr got %h want 0000", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL rst_br_taken got %b want 0", bus.BR_TAKEN); else n_pass++;
      n_total++; if (bus.CC !== 3'b010) $display("FAIL rst_cc got %b want 010", bus.CC); else n_pass++;
   endtask

   task automatic test_add();
      drive(1'b1, 2'b01, 16'h0005, 16'hFFFD, 3'd3, 16'h0);
      n_total++; if (bus.AGEX_RESULT !== 16'h0002) $display("FAIL add_result got %h want 0002", bus.AGEX_RESULT); else n_pass++;
      n_total++; if (bus.OP_EX !== 2'b01) $display("FAIL add_op_ex got %b want 01", bus.OP_EX); else n_pass++;
      n_total++; if (bus.DR_EX !== 3'd3) $display("FAIL add_dr_ex got %0d want 3", bus.DR_EX); else n_pass++;
      n_total++; if (bus.MEM_ADDR !== 16'h0) $display("FAIL add_latency got %h want 0000", bus.MEM_ADDR); else n_pass++;
      step();
      n_total++; if (bus.MEM_ADDR !== 16'h0002) $display("FAIL add_mem_addr got %h want 0002", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.OP_MEM !== 2'b01) $display("FAIL add_op_mem got %b want 01", bus.OP_MEM); else n_pass++;
      n_total++; if (bus.DR_MEM !== 3'd3) $display("FAIL add_dr_mem got %0d want 3", bus.DR_MEM); else n_pass++;
      n_total++; if (bus.MEM_VALID !== 1'b1) $display("FAIL add_mem_valid got %b want 1", bus.MEM_VALID); else n_pass++;
      n_total++; if (bus.CC !== 3'b001) $display("FAIL add_cc_pos got %b want 001", bus.CC); else n_pass++;
      drive(1'b1, 2'b01, 16'h0001, 16'hFFFD, 3'd1, 16'h0);
      step();
      n_total++; if (bus.CC !== 3'b100) $display("FAIL add_cc_neg got %b want 100", bus.CC); else n_pass++;
      drive(1'b1, 2'b01, 16'h0003, 16'hFFFD, 3'd1, 16'h0);
      step();
      n_total++; if (bus.CC !== 3'b010) $display("FAIL add_cc_zero got %b want 010", bus.CC); else n_pass++;
      drive(1'b0, 2'b01, 16'h0001, 16'h0001, 3'd1, 16'h0);
      n_total++; if (bus.OP_EX !== 2'b00) $display("FAIL bubble_op_ex got %b want 00", bus.OP_EX); else n_pass++;
      step();
      n_total++; if (bus.MEM_VALID !== 1'b0) $display("FAIL bubble_mem_valid got %b want 0", bus.MEM_VALID); else n_pass++;
      n_total++; if (bus.CC !== 3'b010) $display("FAIL bubble_cc got %b want 010", bus.CC); else n_pass++;
   endtask

   task automatic test_ldst();
      drive(1'b1, 2'b10, 16'h3000, 16'h1234, 3'd2, 16'hFFFF);
      n_total++; if (bus.AGEX_RESULT !== 16'h2FFE) $display("FAIL ldw_result got %h want 2FFE", bus.AGEX_RESULT); else n_pass++;
      n_total++; if (bus.OP_EX !== 2'b10) $display("FAIL ldw_op_ex got %b want 10", bus.OP_EX); else n_pass++;
      step();
      n_total++; if (bus.MEM_ADDR !== 16'h2FFE) $display("FAIL ldw_mem_addr got %h want 2FFE", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.CC !== 3'b010) $display("FAIL ldw_cc got %b want 010", bus.CC); else n_pass++;
      drive(1'b1, 2'b11, 16'h4000, 16'hBEEF, 3'd0, 16'h0002);
      step();
      n_total++; if (bus.MEM_ADDR !== 16'h4004) $display("FAIL stw_mem_addr got %h want 4004", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.MEM_WDATA !== 16'hBEEF) $display("FAIL stw_wdata got %h want BEEF", bus.MEM_WDATA); else n_pass++;
      n_total++; if (bus.OP_MEM !== 2'b11) $display("FAIL stw_op_mem got %b want 11", bus.OP_MEM); else n_pass++;
      n_total++; if (bus.MEM_VALID !== 1'b1) $display("FAIL stw_mem_valid got %b want 1", bus.MEM_VALID); else n_pass++;
   endtask

   task automatic test_branch();
      drive_br(1'b0, 16'h0020, 16'h0008);
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL brnt_taken got %b want 0", bus.BR_TAKEN); else n_pass++;
      n_total++; if (bus.MEM_VALID !== 1'b0) $display("FAIL brnt_mem_valid got %b want 0", bus.MEM_VALID); else n_pass++;
      drive_br(1'b1, 16'h0010, 16'h0004);
      n_total++; if (bus.OP_EX !== 2'b00) $display("FAIL br_op_ex got %b want 00", bus.OP_EX); else n_pass++;
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b1) $display("FAIL br_taken got %b want 1", bus.BR_TAKEN); else n_pass++;
      n_total++; if (bus.BR_TARGET !== 16'h0018) $display("FAIL br_target got %h want 0018", bus.BR_TARGET); else n_pass++;
      n_total++; if (bus.MEM_VALID !== 1'b0) $display("FAIL br_mem_valid got %b want 0", bus.MEM_VALID); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'b01, 16'h0001, 16'h0001, 3'd4, 16'h0);
         n_total++; if (bus.OP_EX !== 2'b00) $display("FAIL flush_op_ex[%0d] got %b want 00", i, bus.OP_EX); else n_pass++;
         step();
         n_total++; if (bus.MEM_VALID !== 1'b0) $display("FAIL flush_mem_valid[%0d] got %b want 0", i, bus.MEM_VALID); else n_pass++;
         n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL flush_br_taken[%0d] got %b want 0", i, bus.BR_TAKEN); else n_pass++;
      end
      drive(1'b1, 2'b01, 16'h0001, 16'h0001, 3'd4, 16'h0);
      n_total++; if (bus.OP_EX !== 2'b01) $display("FAIL post_flush_op_ex got %b want 01", bus.OP_EX); else n_pass++;
      step();
      n_total++; if (bus.MEM_VALID !== 1'b1) $display("FAIL post_flush_valid got %b want 1", bus.MEM_VALID); else n_pass++;
      n_total++; if (bus.MEM_ADDR !== 16'h0002) $display("FAIL post_flush_addr got %h want 0002", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.CC !== 3'b001) $display("FAIL post_flush_cc got %b want 001", bus.CC); else n_pass++;
   endtask

   task automatic test_stall();
      drive(1'b1, 2'b01, 16'h0010, 16'h0001, 3'd5, 16'h0);
      step();
      drive(1'b1, 2'b01, 16'h8000, 16'h0000, 3'd6, 16'h0);
      bus.MEM_STALL = 1'b1;
      #1;
      n_total++; if (bus.STALL_OUT !== 1'b1) $display("FAIL stall_out got %b want 1", bus.STALL_OUT); else n_pass++;
      n_total++; if (bus.AGEX_RESULT !== 16'h8000) $display("FAIL stall_comb got %h want 8000", bus.AGEX_RESULT); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (bus.MEM_ADDR !== 16'h0011) $display("FAIL stall_addr[%0d] got %h want 0011", i, bus.MEM_ADDR); else n_pass++;
         n_total++; if (bus.DR_MEM !== 3'd5) $display("FAIL stall_dr[%0d] got %0d want 5", i, bus.DR_MEM); else n_pass++;
         n_total++; if (bus.CC !== 3'b001) $display("FAIL stall_cc[%0d] got %b want 001", i, bus.CC); else n_pass++;
      end
      bus.MEM_STALL = 1'b0;
      step();
      n_total++; if (bus.MEM_ADDR !== 16'h8000) $display("FAIL release_addr got %h want 8000", bus.MEM_ADDR); else n_pass++;
      n_total++; if (bus.CC !== 3'b100) $display("FAIL release_cc got %b want 100", bus.CC); else n_pass++;
   endtask

   task automatic test_branch_stall();
      // taken BR seen under stall is deferred to the first free edge
      drive_br(1'b1, 16'h0100, 16'hFFFE);
      bus.MEM_STALL = 1'b1;
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL defer_taken got %b want 0", bus.BR_TAKEN); else n_pass++;
      bus.MEM_STALL = 1'b0;
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b1) $display("FAIL defer_release got %b want 1", bus.BR_TAKEN); else n_pass++;
      n_total++; if (bus.BR_TARGET !== 16'h00FC) $display("FAIL defer_target got %h want 00FC", bus.BR_TARGET); else n_pass++;
      drive(1'b1, 2'b01, 16'h0002, 16'h0002, 3'd1, 16'h0);
      bus.MEM_STALL = 1'b1;
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b1) $display("FAIL hold_taken got %b want 1", bus.BR_TAKEN); else n_pass++;
      bus.MEM_STALL = 1'b0;
      step();
      n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL hold_drop got %b want 0", bus.BR_TAKEN); else n_pass++;
      step();
      drive(1'b1, 2'b01, 16'h0002, 16'h0002, 3'd1, 16'h0);
      n_total++; if (bus.OP_EX !== 2'b01) $display("FAIL stall_flush_done got %b want 01", bus.OP_EX); else n_pass++;
      step();
   endtask

   task automatic test_reset_in_flush();
      drive_br(1'b1, 16'h0040, 16'h0010);
      step();
      drive(1'b1, 2'b01, 16'h0001, 16'h0001, 3'd2, 16'h0);
      n_total++; if (bus.OP_EX !== 2'b00) $display("FAIL rif_in_flush got %b want 00", bus.OP_EX); else n_pass++;
      RESET = 1'b1;
      bus.MEM_STALL = 1'b1;
      step();
      RESET = 1'b0;
      bus.MEM_STALL = 1'b0;
      #1;
      n_total++; if (bus.CC !== 3'b010) $display("FAIL rif_cc got %b want 010", bus.CC); else n_pass++;
      n_total++; if (bus.BR_TAKEN !== 1'b0) $display("FAIL rif_br_taken got %b want 0", bus.BR_TAKEN); else n_pass++;
      n_total++; if (bus.BR_TARGET !== 16'h0) $display("FAIL rif_br_target got %h want 0000", bus.BR_TARGET); else n_pass++;
      n_total++; if (bus.MEM_WDATA !== 16'h0) $display("FAIL rif_wdata got %h want 0000", bus.MEM_WDATA); else n_pass++;
      n_total++; if (bus.OP_EX !== 2'b01) $display("FAIL rif_idle got %b want 01", bus.OP_EX); else n_pass++;
   endtask

`ifdef AGEX_OVF_FLAG_EN
   task automatic test_ovf();
      drive(1'b1, 2'b01, 16'h7FFF, 16'h0001, 3'd1, 16'h0);
      step();
      n_total++; if (bus.MEM_OVF !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.MEM_OVF); else n_pass++;
      drive(1'b1, 2'b01, 16'h0001, 16'h0001, 3'd1, 16'h0);
      step();
      n_total++; if (bus.MEM_OVF !== 1'b0) $display("FAIL ovf_clear got %b want 0", bus.MEM_OVF); else n_pass++;
   endtask
`endif

   initial begin
      n_pass        = 0;
      n_total       = 0;
      RESET         = 1'b1;
      bus.VALID_IN  = 1'b0;
      bus.ALUOP     = 2'b00;
      bus.OPERAND1  = '0;
      bus.OPERAND2  = '0;
      bus.DR_IN     = '0;
      bus.PC_IN     = '0;
      bus.PC_OFFSET = '0;
      bus.MEM_OFFSET = '0;
      bus.BRANCH_IN = 1'b0;
      bus.MEM_STALL = 1'b0;
      test_reset();
      test_add();
      test_ldst();
      test_branch();
      test_stall();
      test_branch_stall();
      test_reset_in_flush();
`ifdef AGEX_OVF_FLAG_EN
      test_ovf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
